// File: rtl/zbus_pkg.sv
// Purpose: shared constants, register bit map and FSM state type for the Z80 I/O responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zbus_pkg;

  // Default full 16-bit I/O port addresses
  localparam logic [15:0] RSTINT_PORT_DEF = 16'h83AB;
  localparam logic [15:0] SL811_PORT_DEF  = 16'h81AB;

  // #83AB reset/interrupt control register bit map
  localparam int RI_W5300_IRQ  = 0;  // read-only, synced ~w5300_int_n
  localparam int RI_SL811_IRQ  = 1;  // read-only, synced sl811_intrq
  localparam int RI_W5300_IEN  = 2;
  localparam int RI_SL811_IEN  = 3;
  localparam int RI_W5300_RST  = 4;  // 1 releases W5300 from reset
  localparam int RI_SL811_RST  = 5;  // 1 releases SL811 from reset
  localparam int RI_EXT_IEN    = 6;  // gates the Z80 INT drive
  localparam int RI_INT        = 7;  // read-only, combined internal interrupt

  // #81AB SL811 mode/power register bit map
  localparam int SL_MS         = 0;  // R/W, sl811_ms_n = ~ms
  localparam int SL_USB_POWER  = 1;  // read-only, synced usb_power

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } zbus_state_t;

endpackage

// File: rtl/sync2.sv
// Purpose: parametrised-width two-flop synchroniser with synchronous active-low reset value.
// Latency: 2 clk edges from input to q.
// Backpressure: none; samples every clk edge.
//
// Ports: clk, rst_n (sync, active low), d [W-1:0] async input, q [W-1:0] synced output.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/zbus_io_resp.sv
// Purpose: clocked Z80 I/O-cycle target for ports #83AB (reset/irq ctl) and #81AB (SL811 mode/power).
// Latency: strobe low sampled at edge N -> FSM/register action at N+2 (N+3 with glitch filter).
// Backpressure: none; the Z80 strobe timing paces every cycle, one action per I/O cycle.
//
// Ports: clk/rst_n (sync, active low); za/zd_in Z80 address and data; zd_out/zd_oe read data and
// bus drive enable; ziorq_n/zrd_n/zwr_n async Z80 strobes; w5300_int_n, sl811_intrq, usb_power
// async status inputs; w5300_rst_n, sl811_rst_n, sl811_ms_n, zint_drv control outputs.
// Build option: define ZBUS_GLITCH_FILTER_EN to add a third strobe stage that rejects 1-clk pulses.
module zbus_io_resp
  import zbus_pkg::*;
#(
  parameter logic [15:0] RSTINT_PORT = RSTINT_PORT_DEF,
  parameter logic [15:0] SL811_PORT  = SL811_PORT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic        ziorq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        w5300_int_n,
  input  logic        sl811_intrq,
  input  logic        usb_power,
  output logic        w5300_rst_n,
  output logic        sl811_rst_n,
  output logic        sl811_ms_n,
  output logic        zint_drv
);

  // Strobe vector order: {wr, rd, iorq}; all idle high.
  logic [2:0] strb_s2;
  logic [2:0] strb_eff;
  logic [2:0] stat_s;

  sync2 #(.W(3), .RST_VAL(3'b111)) u_sync_strb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({zwr_n, zrd_n, ziorq_n}),
    .q     (strb_s2)
  );

  // Status vector order: {usb_power, sl811_intrq, w5300_int_n}; interrupts idle inactive.
  sync2 #(.W(3), .RST_VAL(3'b001)) u_sync_stat (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({usb_power, sl811_intrq, w5300_int_n}),
    .q     (stat_s)
  );

`ifdef ZBUS_GLITCH_FILTER_EN
  // A strobe is low only when two consecutive samples agree, so a single-clk pulse never counts.
  logic [2:0] strb_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_s3 <= 3'b111;
    end else begin
      strb_s3 <= strb_s2;
    end
  end

  assign strb_eff = strb_s2 | strb_s3;
`else
  assign strb_eff = strb_s2;
`endif

  logic iorq_s, rd_s, wr_s;
  logic rdcyc, wrcyc;
  logic sel_rstint, sel_sl811, hit;

  assign iorq_s = strb_eff[0];
  assign rd_s   = strb_eff[1];
  assign wr_s   = strb_eff[2];
  assign rdcyc  = ~iorq_s & ~rd_s;
  assign wrcyc  = ~iorq_s & ~wr_s;

  // za is stable while the strobes are valid, so it is compared unsynchronised.
  assign sel_rstint = (za == RSTINT_PORT);
  assign sel_sl811  = (za == SL811_PORT);
  assign hit        = sel_rstint | sel_sl811;

  logic w5300_irq, sl811_irq, usb_pwr_s;

  assign w5300_irq = ~stat_s[0];
  assign sl811_irq = stat_s[1];
  assign usb_pwr_s = stat_s[2];

  // Writable bits of #83AB live at their own bit positions.
  logic [6:2]  ctl_q;
  logic        ms_q;
  logic        oe_q;
  logic        zint_q;
  zbus_state_t state_q;

  logic       int_irq;
  logic [7:0] rstint_rd;
  logic [7:0] sl811_rd;
  logic [7:0] rd_mux;

  assign int_irq   = |({sl811_irq, w5300_irq} & ctl_q[RI_SL811_IEN:RI_W5300_IEN]);
  assign rstint_rd = {int_irq, ctl_q, sl811_irq, w5300_irq};
  assign sl811_rd  = {6'b0, usb_pwr_s, ms_q};
  assign rd_mux    = sel_rstint ? rstint_rd : sl811_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      oe_q    <= 1'b0;
      zd_out  <= 8'h00;
      ctl_q   <= '0;
      ms_q    <= 1'b1;
      zint_q  <= 1'b0;
    end else begin
      zint_q <= ctl_q[RI_EXT_IEN] & int_irq;
      case (state_q)
        ST_IDLE: begin
          // Read wins over a simultaneous (illegal) write strobe.
          if (rdcyc && hit) begin
            state_q <= ST_READ;
            zd_out  <= rd_mux;
            oe_q    <= 1'b1;
          end else if (wrcyc && hit) begin
            state_q <= ST_WRITE;
            if (sel_rstint) begin
              ctl_q <= zd_in[6:2];
            end else begin
              ms_q <= zd_in[SL_MS];
            end
          end
        end
        ST_READ: begin
          if (iorq_s && rd_s) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
          end
        end
        ST_WRITE: begin
          // Holding here until the strobes rise guarantees one commit per cycle.
          if (iorq_s && wr_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  // Drive release follows the raw strobes so the bus is never held past the Z80 read.
  assign zd_oe       = oe_q & ~ziorq_n & ~zrd_n;
  assign w5300_rst_n = ctl_q[RI_W5300_RST];
  assign sl811_rst_n = ctl_q[RI_SL811_RST];
  assign sl811_ms_n  = ~ms_q;
  assign zint_drv    = zint_q;

  // Data bits with no writable destination.
  logic unused_zd_bits;
  assign unused_zd_bits = ^{zd_in[7], zd_in[1]};

endmodule

// File: tb/tb_zbus_io_resp.sv
module tb_zbus_io_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] za;
  logic [7:0]  zd_in;
  logic [7:0]  zd_out;
  logic        zd_oe;
  logic        ziorq_n, zrd_n, zwr_n;
  logic        w5300_int_n, sl811_intrq, usb_power;
  logic        w5300_rst_n, sl811_rst_n, sl811_ms_n, zint_drv;

  always #5 clk = ~clk;

  zbus_io_resp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .za          (za),
    .zd_in       (zd_in),
    .zd_out      (zd_out),
    .zd_oe       (zd_oe),
    .ziorq_n     (ziorq_n),
    .zrd_n       (zrd_n),
    .zwr_n       (zwr_n),
    .w5300_int_n (w5300_int_n),
    .sl811_intrq (sl811_intrq),
    .usb_power   (usb_power),
    .w5300_rst_n (w5300_rst_n),
    .sl811_rst_n (sl811_rst_n),
    .sl811_ms_n  (sl811_ms_n),
    .zint_drv    (zint_drv)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected read bytes and a reference model of the writable state.
  logic [7:0] exp_q[$];
  logic [6:2] m_ctl;
  logic       m_ms;

  logic [7:0] obs_dat, exp_dat;
  logic       obs_oe, obs_rel;

  function automatic void m_reset();
    m_ctl = '0;
    m_ms  = 1'b1;
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h83AB) m_ctl = d[6:2];
    else if (a == 16'h81AB) m_ms = d[0];
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic w, s, i;
    w = ~w5300_int_n;
    s = sl811_intrq;
    i = (w & m_ctl[2]) | (s & m_ctl[3]);
    if (a == 16'h83AB) return {i, m_ctl, s, w};
    if (a == 16'h81AB) return {6'b0, usb_power, m_ms};
    return 8'h00;
  endfunction

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    za = a; zd_in = d; ziorq_n = 1'b0; zwr_n = 1'b0;
    repeat (hold) @(negedge clk);
    ziorq_n = 1'b1; zwr_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] dat,
                         output logic oe, output logic rel);
    @(negedge clk);
    za = a; ziorq_n = 1'b0; zrd_n = 1'b0;
    repeat (5) @(negedge clk);
    dat = zd_out;
    oe  = zd_oe;
    ziorq_n = 1'b1; zrd_n = 1'b1;
    #1 rel = zd_oe;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    za = 16'h0000; zd_in = 8'h00;
    ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
    w5300_int_n = 1'b1; sl811_intrq = 1'b0; usb_power = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    total++; if (w5300_rst_n !== 1'b0) begin bad++; $display("FAIL reset_w5300_rst_n got=%b want=0", w5300_rst_n); end
    total++; if (sl811_rst_n !== 1'b0) begin bad++; $display("FAIL reset_sl811_rst_n got=%b want=0", sl811_rst_n); end
    total++; if (sl811_ms_n !== 1'b0) begin bad++; $display("FAIL reset_sl811_ms_n got=%b want=0", sl811_ms_n); end
    total++; if (zint_drv !== 1'b0) begin bad++; $display("FAIL reset_zint_drv got=%b want=0", zint_drv); end
    total++; if (zd_oe !== 1'b0) begin bad++; $display("FAIL reset_zd_oe got=%b want=0", zd_oe); end
    total++; if (zd_out !== 8'h00) begin bad++; $display("FAIL reset_zd_out got=%h want=00", zd_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL reset_read_83ab got=%h want=%h", obs_dat, exp_dat); end
    total++; if (obs_oe !== 1'b1) begin bad++; $display("FAIL reset_read_oe got=%b want=1", obs_oe); end
    total++; if (obs_rel !== 1'b0) begin bad++; $display("FAIL reset_read_release got=%b want=0", obs_rel); end
  endtask

  task automatic test_write_rstint();
    io_write(16'h83AB, 8'h74, 5); m_write(16'h83AB, 8'h74);
    total++; if (w5300_rst_n !== 1'b1) begin bad++; $display("FAIL wr83_w5300_rst_n got=%b want=1", w5300_rst_n); end
    total++; if (sl811_rst_n !== 1'b1) begin bad++; $display("FAIL wr83_sl811_rst_n got=%b want=1", sl811_rst_n); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL wr83_readback got=%h want=%h", obs_dat, exp_dat); end
    total++; if (obs_dat[6:2] !== 5'b11101) begin bad++; $display("FAIL wr83_bits62 got=%b want=11101", obs_dat[6:2]); end
  endtask

  task automatic test_interrupt();
    sl811_intrq = 1'b1; w5300_int_n = 1'b1;
    io_write(16'h83AB, 8'h48, 5); m_write(16'h83AB, 8'h48);
    total++; if (zint_drv !== 1'b1) begin bad++; $display("FAIL irq_zint_on got=%b want=1", zint_drv); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== 8'hCA) begin bad++; $display("FAIL irq_read_ca got=%h want=ca", obs_dat); end
    total++; if (exp_dat !== 8'hCA) begin bad++; $display("FAIL irq_model_ca got=%h want=ca", exp_dat); end
    io_write(16'h83AB, 8'h08, 5); m_write(16'h83AB, 8'h08);
    total++; if (zint_drv !== 1'b0) begin bad++; $display("FAIL irq_zint_off got=%b want=0", zint_drv); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL irq_read_8a got=%h want=%h", obs_dat, exp_dat); end
    // W5300 path and exact input-to-zint_drv latency
    sl811_intrq = 1'b0;
    io_write(16'h83AB, 8'h44, 5); m_write(16'h83AB, 8'h44);
    total++; if (zint_drv !== 1'b0) begin bad++; $display("FAIL irq_w5300_idle got=%b want=0", zint_drv); end
    @(negedge clk); w5300_int_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (zint_drv !== 1'b0) begin bad++; $display("FAIL irq_latency_early got=%b want=0", zint_drv); end
    @(negedge clk);
    total++; if (zint_drv !== 1'b1) begin bad++; $display("FAIL irq_latency_3 got=%b want=1", zint_drv); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL irq_read_c5 got=%h want=%h", obs_dat, exp_dat); end
    w5300_int_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (zint_drv !== 1'b0) begin bad++; $display("FAIL irq_w5300_clear got=%b want=0", zint_drv); end
  endtask

  task automatic test_sl811();
    io_write(16'h81AB, 8'h00, 5); m_write(16'h81AB, 8'h00);
    total++; if (sl811_ms_n !== 1'b1) begin bad++; $display("FAIL sl_ms_n_high got=%b want=1", sl811_ms_n); end
    usb_power = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(m_read(16'h81AB));
    io_read(16'h81AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== 8'h02) begin bad++; $display("FAIL sl_read_02 got=%h want=02", obs_dat); end
    io_write(16'h81AB, 8'hFF, 5); m_write(16'h81AB, 8'hFF);
    total++; if (sl811_ms_n !== 1'b0) begin bad++; $display("FAIL sl_ms_n_low got=%b want=0", sl811_ms_n); end
    exp_q.push_back(m_read(16'h81AB));
    io_read(16'h81AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL sl_read_03 got=%h want=%h", obs_dat, exp_dat); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL sl_83ab_untouched got=%h want=%h", obs_dat, exp_dat); end
  endtask

  task automatic test_nonhit();
    logic oe_seen;
    io_write(16'h82AB, 8'hFF, 5);
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL nonhit_83ab got=%h want=%h", obs_dat, exp_dat); end
    exp_q.push_back(m_read(16'h81AB));
    io_read(16'h81AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL nonhit_81ab got=%h want=%h", obs_dat, exp_dat); end
    io_read(16'h7FAB, obs_dat, obs_oe, obs_rel);
    total++; if (obs_oe !== 1'b0) begin bad++; $display("FAIL nonhit_oe_7fab got=%b want=0", obs_oe); end
    // Memory cycles (iorq high) on a matching address must be ignored
    oe_seen = 1'b0;
    @(negedge clk); za = 16'h83AB; zd_in = 8'h00; zrd_n = 1'b0;
    repeat (5) begin @(negedge clk); oe_seen = oe_seen | zd_oe; end
    zrd_n = 1'b1; zwr_n = 1'b0;
    repeat (5) @(negedge clk);
    zwr_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL mem_rd_oe got=%b want=0", oe_seen); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL mem_wr_ignored got=%h want=%h", obs_dat, exp_dat); end
  endtask

  task automatic test_glitch();
    io_write(16'h83AB, 8'h00, 5); m_write(16'h83AB, 8'h00);
    // Single-clk pulse: rejected with the filter, accepted without it
    @(negedge clk);
    za = 16'h83AB; zd_in = 8'h30; ziorq_n = 1'b0; zwr_n = 1'b0;
    @(negedge clk);
    ziorq_n = 1'b1; zwr_n = 1'b1;
    repeat (5) @(negedge clk);
`ifndef ZBUS_GLITCH_FILTER_EN
    m_write(16'h83AB, 8'h30);
`endif
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL glitch_1clk got=%h want=%h", obs_dat, exp_dat); end
    io_write(16'h83AB, 8'h00, 5); m_write(16'h83AB, 8'h00);
    // Pulse held for two samples is accepted in both builds
    io_write(16'h83AB, 8'h30, 2); m_write(16'h83AB, 8'h30);
    total++; if ({sl811_rst_n, w5300_rst_n} !== 2'b11) begin bad++; $display("FAIL glitch_2clk_rst got=%b want=11", {sl811_rst_n, w5300_rst_n}); end
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat[5:4] !== 2'b11) begin bad++; $display("FAIL glitch_2clk_bits got=%b want=11", obs_dat[5:4]); end
  endtask

  task automatic test_reset_midcycle();
    io_write(16'h83AB, 8'h7C, 5); m_write(16'h83AB, 8'h7C);
    @(negedge clk);
    za = 16'h83AB; ziorq_n = 1'b0; zrd_n = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (zd_oe !== 1'b1) begin bad++; $display("FAIL midrst_oe_before got=%b want=1", zd_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (zd_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe_cleared got=%b want=0", zd_oe); end
    total++; if (w5300_rst_n !== 1'b0) begin bad++; $display("FAIL midrst_w5300_rst got=%b want=0", w5300_rst_n); end
    ziorq_n = 1'b1; zrd_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_reset();
    repeat (2) @(negedge clk);
    exp_q.push_back(m_read(16'h83AB));
    io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
    exp_dat = exp_q.pop_front();
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL midrst_read got=%h want=%h", obs_dat, exp_dat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 16'h83AB : 16'h81AB;
      d = 8'($urandom);
      w5300_int_n = 1'($urandom_range(0, 1));
      sl811_intrq = 1'($urandom_range(0, 1));
      usb_power   = 1'($urandom_range(0, 1));
      io_write(a, d, 4); m_write(a, d);
      exp_q.push_back(m_read(16'h83AB));
      exp_q.push_back(m_read(16'h81AB));
      io_read(16'h83AB, obs_dat, obs_oe, obs_rel);
      exp_dat = exp_q.pop_front();
      total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL b2b_83ab[%0d] got=%h want=%h", i, obs_dat, exp_dat); end
      io_read(16'h81AB, obs_dat, obs_oe, obs_rel);
      exp_dat = exp_q.pop_front();
      total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL b2b_81ab[%0d] got=%h want=%h", i, obs_dat, exp_dat); end
      total++; if (zint_drv !== (m_ctl[6] & exp_q.size() == 0 & ((~w5300_int_n & m_ctl[2]) | (sl811_intrq & m_ctl[3])))) begin
        bad++; $display("FAIL b2b_zint[%0d] got=%b", i, zint_drv);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_write_rstint();
    test_interrupt();
    test_sl811();
    test_nonhit();
    test_glitch();
    test_reset_midcycle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
